// File: rtl/riscvmulti_core.sv
// riscvmulti_core: multicycle RV32I-subset core sharing one handshaked memory port,
// with illegal/misalignment traps and a retired-instruction counter.
module riscvmulti_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] instret
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d;
    logic [31:0]          a_q, a_d, b_q, b_d, alu_q, alu_d, data_q, data_d;
    logic [1:0]           cause_q, cause_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic [31:0]          rf_q [32];
    logic                 rf_we;
    logic [31:0]          rf_wd;
    logic [6:0]           opcode, funct7;
    logic [2:0]           funct3;
    logic [4:0]           rd, rs1, rs2;
    logic [31:0]          imm_i, imm_s, imm_b, imm_j, rs1_v, rs2_v, alu_y, alu_r, ea;
    logic                 f3_alu, is_lw, is_sw, is_r, is_i, is_beq, is_jal, take;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign rs1_v  = rs1 == 5'd0 ? 32'd0 : rf_q[rs1];
    assign rs2_v  = rs2 == 5'd0 ? 32'd0 : rf_q[rs2];
    assign f3_alu = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
    assign is_lw  = opcode == OP_LW && funct3 == 3'b010;
    assign is_sw  = opcode == OP_SW && funct3 == 3'b010;
    assign is_r   = opcode == OP_R && f3_alu && (funct7 == 7'h00 || (funct7 == 7'h20 && funct3 == 3'b000));
    assign is_i   = opcode == OP_I && f3_alu;
    assign is_beq = opcode == OP_BR && funct3 == 3'b000;
    assign is_jal = opcode == OP_JAL;
    assign take   = a_q == b_q;
    assign ea     = a_q + (opcode == OP_SW ? imm_s : imm_i);
    assign alu_y  = state_q == EXECI ? imm_i : b_q;
    // funct7[5] is an immediate bit for I-type, so subtract only in EXECR
    assign alu_r  = funct3 == 3'b111 ? a_q & alu_y :
                    funct3 == 3'b110 ? a_q | alu_y :
                    funct3 == 3'b010 ? {31'd0, $signed(a_q) < $signed(alu_y)} :
                    (state_q == EXECR && funct7[5]) ? a_q - alu_y : a_q + alu_y;
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        old_pc_d  = old_pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        data_d    = data_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        rf_we     = 1'b0;
        rf_wd     = alu_q;
        case (state_q)
            FETCH: if (mem_ready) begin
                ir_d     = mem_rdata;
                old_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
                state_d  = DECODE;
            end
            DECODE: begin
                a_d     = rs1_v;
                b_d     = rs2_v;
                alu_d   = old_pc_q + (is_jal ? imm_j : imm_b);
                state_d = (is_lw || is_sw) ? MEMADR : is_r ? EXECR : is_i ? EXECI :
                          is_beq ? BEQ : is_jal ? JAL : TRAP;
                cause_d = (is_lw || is_sw || is_r || is_i || is_beq || is_jal) ? 2'd0 : 2'd1;
            end
            MEMADR: begin
                alu_d   = ea;
                state_d = ea[1:0] != 2'd0 ? TRAP : opcode == OP_LW ? MEMREAD : MEMWRITE;
                cause_d = ea[1:0] != 2'd0 ? 2'd2 : 2'd0;
            end
            MEMREAD: if (mem_ready) begin
                data_d  = mem_rdata;
                state_d = MEMWB;
            end
            MEMWB: begin
                rf_we     = 1'b1;
                rf_wd     = data_q;
                instret_d = instret_q + CNT_WIDTH'(1);
                state_d   = FETCH;
            end
            MEMWRITE: if (mem_ready) begin
                instret_d = instret_q + CNT_WIDTH'(1);
                state_d   = FETCH;
            end
            EXECR, EXECI: begin
                alu_d   = alu_r;
                state_d = ALUWB;
            end
            ALUWB: begin
                rf_we     = 1'b1;
                instret_d = instret_q + CNT_WIDTH'(1);
                state_d   = FETCH;
            end
            BEQ: if (take && alu_q[1:0] != 2'd0) begin
                state_d = TRAP;
                cause_d = 2'd3;
            end else begin
                pc_d      = take ? alu_q : pc_q;
                instret_d = instret_q + CNT_WIDTH'(1);
                state_d   = FETCH;
            end
            JAL: if (alu_q[1:0] != 2'd0) begin
                state_d = TRAP;
                cause_d = 2'd3;
            end else begin
                pc_d    = alu_q;
                alu_d   = old_pc_q + 32'd4;
                state_d = ALUWB;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            old_pc_q  <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            data_q    <= '0;
            cause_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            old_pc_q  <= old_pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            data_q    <= data_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wd;
    end
    // reset_n gates the request so it falls the instant reset asserts
    assign mem_req    = reset_n && (state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE);
    assign mem_we     = state_q == MEMWRITE;
    assign mem_addr   = state_q == FETCH ? pc_q : alu_q;
    assign mem_wdata  = b_q;
    assign halted     = state_q == TRAP;
    assign trap_cause = cause_q;
    assign instret    = instret_q;
endmodule

// File: tb/tb_riscvmulti_core.sv
// tb_riscvmulti_core: drives programs through a unified memory with optional random
// wait states and compares against an instruction-level reference model.
module tb_riscvmulti_core;
    typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_ANDI, K_ORI, K_SLTI,
                  K_LW, K_SW, K_BEQ, K_JAL, K_ILL} kind_e;
    typedef struct {kind_e k; int rd; int rs1; int rs2; int imm; logic [31:0] raw;} instr_t;
    typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} xfer_t;
    logic        clk = 0, reset_n = 0, mem_ready = 0;
    logic        mem_req, mem_we, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, instret;
    logic [1:0]  trap_cause;
    logic [31:0] mem [256];
    instr_t      prog[$];
    xfer_t       wlog[$], rlog[$], exp_w[$];
    int          exp_n, exp_cause, checks = 0, fails = 0, cyc = 0, hold_err = 0, first_halt = -1;
    int          ready_mode = 0;
    bit          block_we = 0, pend = 0, p_we = 0;
    logic [31:0] p_addr = 0, p_wd = 0;
    assign mem_rdata = mem[mem_addr[9:2]];
    riscvmulti_core dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .halted(halted), .trap_cause(trap_cause), .instret(instret)
    );
    always #5 clk = ~clk;
    function automatic instr_t mk(kind_e k, int rd, int rs1, int rs2, int imm);
        instr_t i;
        i.k = k; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.raw = 32'h0;
        return i;
    endfunction
    function automatic logic [31:0] enc(instr_t i);
        logic [31:0] m;
        logic [4:0]  d, s1, s2;
        m = i.imm; d = 5'(i.rd); s1 = 5'(i.rs1); s2 = 5'(i.rs2);
        case (i.k)
            K_ADD:  return {7'h00, s2, s1, 3'd0, d, 7'h33};
            K_SUB:  return {7'h20, s2, s1, 3'd0, d, 7'h33};
            K_AND:  return {7'h00, s2, s1, 3'd7, d, 7'h33};
            K_OR:   return {7'h00, s2, s1, 3'd6, d, 7'h33};
            K_SLT:  return {7'h00, s2, s1, 3'd2, d, 7'h33};
            K_ADDI: return {m[11:0], s1, 3'd0, d, 7'h13};
            K_ANDI: return {m[11:0], s1, 3'd7, d, 7'h13};
            K_ORI:  return {m[11:0], s1, 3'd6, d, 7'h13};
            K_SLTI: return {m[11:0], s1, 3'd2, d, 7'h13};
            K_LW:   return {m[11:0], s1, 3'd2, d, 7'h03};
            K_SW:   return {m[11:5], s2, s1, 3'd2, m[4:0], 7'h23};
            K_BEQ:  return {m[12], m[10:5], s2, s1, 3'd0, m[4:1], m[11], 7'h63};
            K_JAL:  return {m[20], m[10:1], m[11], m[19:12], d, 7'h6f};
            default: return i.raw;
        endcase
    endfunction
    // Executes the structured program directly; stops at the jal-to-self idle loop or a trap
    task automatic iss();
        logic [31:0] x [32];
        logic [31:0] dm [256];
        logic [31:0] pc, a, b, iv, ea, r, t;
        instr_t in;
        bit wr;
        foreach (x[i]) x[i] = 0;
        foreach (dm[i]) dm[i] = 0;
        exp_w.delete(); exp_n = 0; exp_cause = 0; pc = 0;
        for (int s = 0; s < 4000; s++) begin
            in = prog[pc >> 2];
            if (in.k == K_JAL && in.imm == 0) break;
            a = x[in.rs1]; b = x[in.rs2]; iv = in.imm; ea = a + iv; wr = 1; r = 0; t = pc + 4;
            case (in.k)
                K_ADD:  r = a + b;
                K_SUB:  r = a - b;
                K_AND:  r = a & b;
                K_OR:   r = a | b;
                K_SLT:  r = $signed(a) < $signed(b) ? 1 : 0;
                K_ADDI: r = a + iv;
                K_ANDI: r = a & iv;
                K_ORI:  r = a | iv;
                K_SLTI: r = $signed(a) < $signed(iv) ? 1 : 0;
                K_LW:   if (ea[1:0] != 0) exp_cause = 2; else r = dm[ea[9:2]];
                K_SW: begin
                    wr = 0;
                    if (ea[1:0] != 0) exp_cause = 2;
                    else begin dm[ea[9:2]] = b; exp_w.push_back('{ea, b, 0}); end
                end
                K_BEQ: begin
                    wr = 0;
                    if (a == b) begin
                        if (((pc + iv) & 3) != 0) exp_cause = 3; else t = pc + iv;
                    end
                end
                K_JAL: if (((pc + iv) & 3) != 0) exp_cause = 3; else begin r = pc + 4; t = pc + iv; end
                default: exp_cause = 1;
            endcase
            if (exp_cause != 0) break;
            if (wr && in.rd != 0) x[in.rd] = r;
            pc = t;
            exp_n++;
        end
    endtask
    task automatic load_prog();
        foreach (mem[i]) mem[i] = 0;
        foreach (prog[i]) mem[i] = enc(prog[i]);
    endtask
    task automatic do_reset();
        reset_n = 0; mem_ready = 0;
        @(negedge clk); @(negedge clk);
        wlog.delete(); rlog.delete();
        hold_err = 0; pend = 0; first_halt = -1; cyc = 0;
        reset_n = 1;
    endtask
    // One clock: choose ready, log any completing transfer, note held-request changes
    task automatic step();
        cyc++;
        #1;
        mem_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        if (block_we && mem_we) mem_ready = 0;
        if (pend && (mem_req !== 1'b1 || mem_we !== p_we || mem_addr !== p_addr || (p_we && mem_wdata !== p_wd)))
            hold_err++;
        pend = mem_req && !mem_ready; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr[9:2]] = mem_wdata;
                wlog.push_back('{mem_addr, mem_wdata, cyc});
            end else rlog.push_back('{mem_addr, 32'h0, cyc});
        end
        @(posedge clk); @(negedge clk);
        if (halted && first_halt < 0) first_halt = cyc + 1;
    endtask
    task automatic run_until(input int target, input bit use_target, output bit to);
        to = 1;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (halted || (use_target && instret == 32'(target))) begin to = 0; break; end
        end
    endtask
    task automatic test_reset();
        prog.delete();
        prog.push_back(mk(K_JAL, 0, 0, 0, 0));
        load_prog();
        reset_n = 0; mem_ready = 1;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %0b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %0h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %0h want 0", mem_wdata); end
        checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %0b want 0", halted); end
        checks++; if (trap_cause !== 2'd0) begin fails++; $display("FAIL reset_cause got %0d want 0", trap_cause); end
        checks++; if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret got %0d want 0", instret); end
        do_reset();
        #1;
        checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL release_req got %0b want 1", mem_req); end
    endtask
    task automatic test_basic();
        bit to;
        prog.delete();
        prog.push_back(mk(K_ADDI, 1, 0, 0, 5));
        prog.push_back(mk(K_ADDI, 2, 0, 0, -3));
        prog.push_back(mk(K_ADD, 3, 1, 2, 0));
        prog.push_back(mk(K_SW, 0, 0, 3, 100));
        prog.push_back(mk(K_JAL, 0, 0, 0, 0));
        load_prog(); iss(); ready_mode = 0; do_reset();
        run_until(exp_n, 1, to);
        checks++; if (to) begin fails++; $display("FAIL basic_timeout instret=%0d want %0d", instret, exp_n); end
        checks++; if (wlog.size() != 1) begin fails++; $display("FAIL basic_nwrites got %0d want 1", wlog.size()); end
        else begin
            checks++; if (wlog[0].addr !== 32'd100 || wlog[0].data !== 32'd2 || wlog[0].cyc != 16) begin
                fails++; $display("FAIL basic_write got addr=%0d data=%0d cyc=%0d want 100/2/16", wlog[0].addr, wlog[0].data, wlog[0].cyc);
            end
        end
        checks++; if (instret !== 32'd4) begin fails++; $display("FAIL basic_instret got %0d want 4", instret); end
    endtask
    task automatic test_program();
        bit to;
        prog.delete();
        prog.push_back(mk(K_ADDI, 2, 0, 0, 5));
        prog.push_back(mk(K_ADDI, 3, 0, 0, 12));
        prog.push_back(mk(K_ADDI, 7, 3, 0, -9));
        prog.push_back(mk(K_OR, 4, 7, 2, 0));
        prog.push_back(mk(K_AND, 5, 3, 4, 0));
        prog.push_back(mk(K_ADD, 5, 5, 4, 0));
        prog.push_back(mk(K_BEQ, 0, 5, 7, 48));
        prog.push_back(mk(K_SLT, 4, 3, 4, 0));
        prog.push_back(mk(K_BEQ, 0, 4, 0, 8));
        prog.push_back(mk(K_ADDI, 5, 0, 0, 0));
        prog.push_back(mk(K_SLT, 4, 7, 2, 0));
        prog.push_back(mk(K_ADD, 7, 4, 5, 0));
        prog.push_back(mk(K_SUB, 7, 7, 2, 0));
        prog.push_back(mk(K_SW, 0, 3, 7, 84));
        prog.push_back(mk(K_LW, 2, 0, 0, 96));
        prog.push_back(mk(K_ADD, 9, 2, 5, 0));
        prog.push_back(mk(K_JAL, 3, 0, 0, 8));
        prog.push_back(mk(K_ADDI, 2, 0, 0, 1));
        prog.push_back(mk(K_ADD, 2, 2, 9, 0));
        prog.push_back(mk(K_SW, 0, 3, 2, 32));
        prog.push_back(mk(K_JAL, 0, 0, 0, 0));
        load_prog(); iss(); ready_mode = 1; do_reset();
        run_until(exp_n, 1, to);
        checks++; if (to) begin fails++; $display("FAIL prog_timeout instret=%0d want %0d", instret, exp_n); end
        foreach (wlog[i]) begin
            checks++; if (wlog[i].addr !== 32'd96 && wlog[i].addr !== 32'd100) begin
                fails++; $display("FAIL prog_waddr[%0d] got %0d want 96 or 100", i, wlog[i].addr);
            end
        end
        checks++; if (wlog.size() == 0 || wlog[$].addr !== 32'd100 || wlog[$].data !== 32'd25) begin
            fails++; $display("FAIL prog_final got n=%0d want last write 25 at 100", wlog.size());
        end
        checks++; if (wlog.size() != exp_w.size()) begin fails++; $display("FAIL prog_nwrites got %0d want %0d", wlog.size(), exp_w.size()); end
        checks++; if (hold_err != 0) begin fails++; $display("FAIL prog_hold got %0d unstable cycles want 0", hold_err); end
        checks++; if (instret !== 32'(exp_n)) begin fails++; $display("FAIL prog_instret got %0d want %0d", instret, exp_n); end
        ready_mode = 0;
    endtask
    task automatic test_beq();
        bit to;
        int ecyc[6] = '{1, 5, 8, 11, 15, 18};
        int eadr[6] = '{0, 4, 8, 16, 20, 12};
        prog.delete();
        prog.push_back(mk(K_ADDI, 1, 0, 0, 7));
        prog.push_back(mk(K_BEQ, 0, 0, 1, 102));
        prog.push_back(mk(K_BEQ, 0, 1, 1, 8));
        prog.push_back(mk(K_JAL, 0, 0, 0, 12));
        prog.push_back(mk(K_ADDI, 1, 1, 0, -7));
        prog.push_back(mk(K_BEQ, 0, 1, 0, -8));
        prog.push_back(mk(K_JAL, 0, 0, 0, 0));
        load_prog(); iss(); ready_mode = 0; do_reset();
        run_until(exp_n, 1, to);
        checks++; if (to || instret !== 32'(exp_n)) begin fails++; $display("FAIL beq_instret got %0d want %0d", instret, exp_n); end
        checks++; if (rlog.size() < 6) begin fails++; $display("FAIL beq_nfetch got %0d want >=6", rlog.size()); end
        else for (int i = 0; i < 6; i++) begin
            checks++; if (rlog[i].cyc != ecyc[i] || rlog[i].addr !== 32'(eadr[i])) begin
                fails++; $display("FAIL beq_fetch[%0d] got cyc=%0d addr=%0d want cyc=%0d addr=%0d", i, rlog[i].cyc, rlog[i].addr, ecyc[i], eadr[i]);
            end
        end
    endtask
    task automatic test_misaligned_load();
        bit to;
        int reqs = 0;
        logic [31:0] n0;
        prog.delete();
        prog.push_back(mk(K_ADDI, 1, 0, 0, 9));
        prog.push_back(mk(K_LW, 5, 0, 0, 2));
        prog.push_back(mk(K_JAL, 0, 0, 0, 0));
        load_prog(); iss(); ready_mode = 0; do_reset();
        run_until(0, 0, to);
        n0 = instret;
        checks++; if (to || halted !== 1'b1) begin fails++; $display("FAIL lwtrap_halted got %0b want 1", halted); end
        checks++; if (trap_cause !== 2'(exp_cause)) begin fails++; $display("FAIL lwtrap_cause got %0d want %0d", trap_cause, exp_cause); end
        checks++; if (instret !== 32'(exp_n)) begin fails++; $display("FAIL lwtrap_instret got %0d want %0d", instret, exp_n); end
        for (int i = 0; i < 8; i++) begin
            if (mem_req) reqs++;
            step();
        end
        checks++; if (reqs != 0 || instret !== n0 || halted !== 1'b1) begin
            fails++; $display("FAIL lwtrap_sticky got reqs=%0d instret=%0d want 0/%0d", reqs, instret, n0);
        end
    endtask
    task automatic test_illegal();
        bit to;
        instr_t il;
        il = mk(K_ILL, 0, 0, 0, 0);
        il.raw = 32'h0000_007f;
        prog.delete();
        prog.push_back(il);
        load_prog(); iss(); ready_mode = 0; do_reset();
        run_until(0, 0, to);
        checks++; if (to || trap_cause !== 2'(exp_cause)) begin fails++; $display("FAIL ill_cause got %0d want %0d", trap_cause, exp_cause); end
        checks++; if (first_halt != 3) begin fails++; $display("FAIL ill_cycle got %0d want 3", first_halt); end
        checks++; if (instret !== 32'd0) begin fails++; $display("FAIL ill_instret got %0d want 0", instret); end
    endtask
    task automatic test_branch_trap();
        bit to;
        for (int v = 0; v < 2; v++) begin
            prog.delete();
            prog.push_back(mk(K_ADDI, 1, 0, 0, 1));
            prog.push_back(v == 0 ? mk(K_BEQ, 0, 0, 0, 6) : mk(K_JAL, 1, 0, 0, 6));
            prog.push_back(mk(K_JAL, 0, 0, 0, 0));
            load_prog(); iss(); ready_mode = 0; do_reset();
            run_until(0, 0, to);
            checks++; if (to || trap_cause !== 2'(exp_cause) || instret !== 32'(exp_n)) begin
                fails++; $display("FAIL brtrap[%0d] got cause=%0d instret=%0d want %0d/%0d", v, trap_cause, instret, exp_cause, exp_n);
            end
        end
    endtask
    task automatic test_reset_mid_write();
        bit to;
        prog.delete();
        prog.push_back(mk(K_ADDI, 1, 0, 0, 3));
        prog.push_back(mk(K_SW, 0, 0, 1, 100));
        prog.push_back(mk(K_JAL, 0, 0, 0, 0));
        load_prog(); iss(); ready_mode = 0; block_we = 1; do_reset();
        for (int i = 0; i < 50 && !(mem_req && mem_we); i++) step();
        step(); step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin fails++; $display("FAIL rst_inwrite got req=%0b we=%0b want 1/1", mem_req, mem_we); end
        #1; reset_n = 0; #1;
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_dropreq got %0b want 0", mem_req); end
        mem_ready = 1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b0 || instret !== 32'd0 || mem_addr !== 32'h0) begin
            fails++; $display("FAIL rst_held got req=%0b instret=%0d addr=%0h want 0/0/0", mem_req, instret, mem_addr);
        end
        checks++; if (wlog.size() != 0) begin fails++; $display("FAIL rst_nowrite got %0d writes want 0", wlog.size()); end
        block_we = 0;
        do_reset();
        run_until(exp_n, 1, to);
        checks++; if (to || rlog.size() == 0 || rlog[0].addr !== 32'h0) begin fails++; $display("FAIL rst_refetch got n=%0d want fetch at 0", rlog.size()); end
        checks++; if (wlog.size() != 1 || wlog[0].addr !== 32'd100 || wlog[0].data !== 32'd3) begin
            fails++; $display("FAIL rst_rerun got n=%0d want one write 3 at 100", wlog.size());
        end
    endtask
    task automatic test_random();
        bit to;
        kind_e ks[9] = '{K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_ANDI, K_ORI, K_SLTI};
        for (int it = 0; it < 4; it++) begin
            prog.delete();
            for (int r = 1; r < 8; r++) prog.push_back(mk(K_ADDI, r, 0, 0, int'($urandom_range(0, 4095)) - 2048));
            for (int j = 0; j < 10; j++)
                prog.push_back(mk(ks[$urandom_range(0, 8)], int'($urandom_range(1, 7)), int'($urandom_range(0, 7)),
                                  int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)) - 2048));
            for (int r = 1; r < 8; r++) prog.push_back(mk(K_SW, 0, 0, r, 128 + 4 * r));
            prog.push_back(mk(K_LW, 8, 0, 0, 128 + 4 * int'($urandom_range(1, 7))));
            prog.push_back(mk(K_SW, 0, 0, 8, 200));
            prog.push_back(mk(K_JAL, 0, 0, 0, 0));
            load_prog(); iss(); ready_mode = 1; do_reset();
            run_until(exp_n, 1, to);
            checks++; if (to || halted !== 1'b0 || instret !== 32'(exp_n)) begin
                fails++; $display("FAIL rnd%0d_instret got %0d halted=%0b want %0d", it, instret, halted, exp_n);
            end
            checks++; if (wlog.size() != exp_w.size()) begin fails++; $display("FAIL rnd%0d_nwrites got %0d want %0d", it, wlog.size(), exp_w.size()); end
            else foreach (exp_w[i]) begin
                checks++; if (wlog[i].addr !== exp_w[i].addr || wlog[i].data !== exp_w[i].data) begin
                    fails++; $display("FAIL rnd%0d_w[%0d] got %0h@%0d want %0h@%0d", it, i, wlog[i].data, wlog[i].addr, exp_w[i].data, exp_w[i].addr);
                end
            end
            checks++; if (hold_err != 0) begin fails++; $display("FAIL rnd%0d_hold got %0d want 0", it, hold_err); end
        end
        ready_mode = 0;
    endtask
    initial begin
        test_reset();
        test_basic();
        test_program();
        test_beq();
        test_misaligned_load();
        test_illegal();
        test_branch_trap();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/riscvmulti_core.md
# riscvmulti_core

Multicycle RV32I-subset processor core, the successor to the single-cycle core. It executes one instruction over 3–5 cycles through a controller FSM and uses a single shared instruction/data memory port with a request/ready handshake, so it tolerates memories with arbitrary wait states. It adds `jal`, I-type ALU ops, an illegal-instruction/misalignment trap and a retired-instruction counter. It sits between the existing top-level wrapper and a unified memory model.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `CNT_WIDTH`, default `32`: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `mem_req`, output, 1: memory request, held until accepted.
- `mem_we`, output, 1: 1 = write, 0 = read. Valid while `mem_req`.
- `mem_addr`, output, 32: byte address, always word-aligned when `mem_req`.
- `mem_wdata`, output, 32: store data. Valid while `mem_req & mem_we`.
- `mem_rdata`, input, 32: read data, sampled in the cycle `mem_ready` is high.
- `mem_ready`, input, 1: transfer completes in any cycle where `mem_req & mem_ready`.
- `halted`, output, 1: core is in TRAP; sticky until reset.
- `trap_cause`, output, 2: 0 = none, 1 = illegal opcode/funct, 2 = misaligned data address, 3 = misaligned branch/jump target.
- `instret`, output, CNT_WIDTH: count of retired instructions; wraps modulo 2^CNT_WIDTH.

## Operation
- Architectural state: `PC`, x1–x31, with x0 reading as 0 and writes to it discarded.
- Internal registers: `OldPC`, `IR`, `A`, `B`, `ALUOut`, `Data`.
- Supported instructions:
  - `lw`, `sw`
  - R-type: `add`, `sub`, `and`, `or`, `slt`
  - I-type: `addi`, `andi`, `ori`, `slti`
  - `beq`, `jal`
  - Anything else, including unsupported funct3/funct7, traps with cause 1.
- FSM states and transitions:
  - FETCH: `mem_req=1`, `mem_we=0`, `mem_addr=PC`. Stays in FETCH while not ready. On ready: `IR<=mem_rdata`, `OldPC<=PC`, `PC<=PC+4`, go to DECODE.
  - DECODE: `A<=rs1`, `B<=rs2`, `ALUOut<=OldPC+imm` (B/J immediate). Next state by opcode: lw/sw→MEMADR, R→EXECR, I→EXECI, beq→BEQ, jal→JAL, other→TRAP(1).
  - MEMADR: `ALUOut<=A+imm`. If `addr[1:0]!=0` go to TRAP(2); else lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD: read request at `ALUOut` until ready, latch `Data`, go to MEMWB.
  - MEMWB: `rd<=Data`, retire, go to FETCH.
  - MEMWRITE: write request with `mem_wdata=B`. On ready, retire and go to FETCH.
  - EXECR / EXECI: `ALUOut<=A op B` or `A op imm`, go to ALUWB.
  - ALUWB: `rd<=ALUOut`, retire, go to FETCH.
  - BEQ: if `A==B` and `ALUOut[1:0]!=0`, go to TRAP(3). Otherwise, if `A==B`, `PC<=ALUOut`. Retire, go to FETCH.
  - JAL: if `ALUOut[1:0]!=0`, go to TRAP(3). Else `PC<=ALUOut`, `ALUOut<=OldPC+4`, go to ALUWB.
  - TRAP: `halted=1`, `mem_req=0`, no further state change.
- Arithmetic:
  - All arithmetic is 32-bit two's complement with no overflow exception.
  - `slt`/`slti` are signed and produce 0 or 1.
  - Immediates are sign-extended.
- Retire means `instret<=instret+1`. It happens exactly once per completed instruction and never for trapping ones.

## Timing
- Reset values:
  - `PC=RESET_PC`, FSM in FETCH.
  - `mem_req=0` during reset; it asserts in the first cycle after `reset_n` rises.
  - `mem_we=0`, `mem_addr=RESET_PC`, `mem_wdata=0`.
  - `halted=0`, `trap_cause=0`, `instret=0`.
  - Register file contents are not reset.
- `reset_n` low at any point, including mid-transfer, clears state immediately and drops `mem_req` combinationally with reset. No partial write is committed by the core.
- Memory outputs are registered/FSM-decoded and stable for the whole request. They change only on the cycle after acceptance.
- `mem_ready` while `mem_req=0` is ignored.
- Cycles per instruction with zero-wait memory (`mem_ready` tied high):
  - `lw` 5
  - `sw` 4
  - R-type / I-type 4
  - `jal` 4
  - `beq` 3
- Each wait cycle on a transfer adds exactly one cycle.
- A register written in the final cycle of an instruction is visible to the next instruction's DECODE.

## Test plan
- Reset then 4 instructions `addi x1,x0,5`; `addi x2,x0,-3`; `add x3,x1,x2`; `sw x3,100(x0)`, zero-wait → write at addr 100 with data 2 on cycle 16; `instret=4` afterwards.
- Standard 25-at-100 test program (lw/sw/R/I/beq/jal mix) with `mem_ready` randomly low 50% of the time → the only writes are to addresses 96 and 100, the final write is data 25 at address 100, and every request holds its addr/we/wdata stable until ready.
- `beq` taken and not taken, zero-wait → each takes 3 cycles; taken with offset -8 → next fetch address is OldPC-8.
- `lw x5,2(x0)` → `halted=1`, `trap_cause=2`, no further `mem_req`, `instret` unchanged.
- Opcode `7'b1111111` → TRAP, `trap_cause=1` at the cycle after DECODE.
- Drop `reset_n` mid-MEMWRITE wait → `mem_req` low immediately, no write recorded. After release, fetch starts from `RESET_PC` with `instret=0`.
